// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the pixel/TMDS
// consumers (slave); en is the consumer's run request back to the generator.
interface video_timing_gen_if #(
    parameter int CW = 10
);
    logic          en;
    logic          running;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output running, x, y, de, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output en,
        input  running, x, y, de, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parameterised raster timing generator feeding the TMDS encoders: counters plus a
// run/stop FSM that only ever stops on a frame boundary, with all outputs registered.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Region bounds carry one extra bit so a window ending exactly at 2^CW stays representable.
    localparam logic [CW:0] H_DE_END   = (CW + 1)'(H_ACTIVE);
    localparam logic [CW:0] HS_START   = (CW + 1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END     = (CW + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_DE_END   = (CW + 1)'(V_ACTIVE);
    localparam logic [CW:0] VS_START   = (CW + 1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END     = (CW + 1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t        state;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;

    logic          h_end;
    logic          v_end;
    logic          de_next;
    logic          hsync_next;
    logic          vsync_next;

    assign h_end = (cx == H_LAST);
    assign v_end = (cy == V_LAST);

    always_comb begin
        de_next    = ({1'b0, cx} < H_DE_END) && ({1'b0, cy} < V_DE_END);
        hsync_next = (({1'b0, cx} >= HS_START) && ({1'b0, cx} < HS_END)) ? HS_POL : ~HS_POL;
        vsync_next = (({1'b0, cy} >= VS_START) && ({1'b0, cy} < VS_END)) ? VS_POL : ~VS_POL;
    end

    // Outputs decode the pre-edge (cx, cy, state); running follows the FSM on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cx             <= '0;
            cy             <= '0;
            vt.running     <= 1'b0;
            vt.x           <= '0;
            vt.y           <= '0;
            vt.de          <= 1'b0;
            vt.hsync       <= ~HS_POL;
            vt.vsync       <= ~VS_POL;
            vt.line_start  <= 1'b0;
            vt.frame_start <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cx             <= '0;
                    cy             <= '0;
                    vt.x           <= '0;
                    vt.y           <= '0;
                    vt.de          <= 1'b0;
                    vt.hsync       <= ~HS_POL;
                    vt.vsync       <= ~VS_POL;
                    vt.line_start  <= 1'b0;
                    vt.frame_start <= 1'b0;
                    if (vt.en) begin
                        state      <= RUN;
                        vt.running <= 1'b1;
                    end else begin
                        vt.running <= 1'b0;
                    end
                end

                RUN, STOPPING: begin
                    vt.x           <= cx;
                    vt.y           <= cy;
                    vt.de          <= de_next;
                    vt.hsync       <= hsync_next;
                    vt.vsync       <= vsync_next;
                    vt.line_start  <= (cx == '0);
                    vt.frame_start <= (cx == '0) && (cy == '0);

                    cx <= h_end ? '0 : cx + CW'(1);
                    if (h_end) begin
                        cy <= v_end ? '0 : cy + CW'(1);
                    end

                    // A renewed run request wins over the end-of-frame stop.
                    if (vt.en) begin
                        state      <= RUN;
                        vt.running <= 1'b1;
                    end else if ((state == STOPPING) && h_end && v_end) begin
                        state      <= IDLE;
                        vt.running <= 1'b0;
                    end else begin
                        state      <= STOPPING;
                        vt.running <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    vt.running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a linear-frame-position reference model pushes
// the expected output of every cycle; a monitor pops and compares each observed cycle.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 12;
    localparam int H_FP     = 3;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 5;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam bit HS_POL   = 1'b1;
    localparam bit VS_POL   = 1'b0;
    localparam int CW       = 5;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic          running;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de;
        logic          hsync;
        logic          vsync;
        logic          line_start;
        logic          frame_start;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;

    video_timing_gen_if #(.CW(CW)) vtIf ();

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .CW       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vt    (vtIf)
    );

    always #5 clk = ~clk;

    obs_t expQueue[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    // Reference model: whether the raster is active, linear position in the frame, last sampled en.
    bit   modelActive  = 1'b0;
    int   modelPos     = 0;
    bit   modelPrevEn  = 1'b0;

    function automatic obs_t idleObs();
        obs_t o;
        o       = '0;
        o.hsync = ~HS_POL;
        o.vsync = ~VS_POL;
        return o;
    endfunction

    function automatic obs_t pixelObs(int pos);
        obs_t o;
        int   px;
        int   py;
        px            = pos % H_TOTAL;
        py            = pos / H_TOTAL;
        o             = '0;
        o.x           = CW'(px);
        o.y           = CW'(py);
        o.de          = (px < H_ACTIVE) && (py < V_ACTIVE);
        o.hsync       = (px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
        o.vsync       = (py >= V_ACTIVE + V_FP && py < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
        o.line_start  = (px == 0);
        o.frame_start = (pos == 0);
        return o;
    endfunction

    function automatic string fmtObs(obs_t o);
        return $sformatf("run=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                         o.running, o.x, o.y, o.de, o.hsync, o.vsync, o.line_start, o.frame_start);
    endfunction

    // Called right after a rising edge: advance the model by the edge just taken.
    task automatic stepModel();
        obs_t o;
        if (!rst_n) begin
            modelActive = 1'b0;
            modelPos    = 0;
            o           = idleObs();
        end else if (!modelActive) begin
            o = idleObs();
            if (vtIf.en) begin
                modelActive = 1'b1;
                modelPos    = 0;
                modelPrevEn = 1'b1;
            end
        end else begin
            o = pixelObs(modelPos);
            if (modelPos == FRAME - 1 && !modelPrevEn && !vtIf.en) begin
                modelActive = 1'b0;
            end
            modelPos    = (modelPos + 1) % FRAME;
            modelPrevEn = vtIf.en;
        end
        o.running = modelActive;
        expQueue.push_back(o);
    endtask

    // Hold en at newEn for the given number of cycles, never re-raising it on a stopping last pixel.
    task automatic applyStimulus(bit newEn, int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            stepModel();
            #2;
            if (newEn && modelActive && !modelPrevEn && modelPos == FRAME - 1) begin
                vtIf.en = 1'b0;
            end else begin
                vtIf.en = newEn;
            end
        end
    endtask

    // Assert reset between edges, so the monitor sees the outputs drop before any clock.
    task automatic applyReset(int holdCycles, bit enAfter);
        @(posedge clk);
        stepModel();
        #3;
        expQueue.delete();
        expQueue.push_back(idleObs());
        expQueue.push_back(idleObs());
        modelActive = 1'b0;
        rst_n       = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            stepModel();
        end
        #2;
        rst_n   = 1'b1;
        vtIf.en = enAfter;
    endtask

    task automatic checkOutput();
        obs_t act;
        obs_t exp;
        act.running     = vtIf.running;
        act.x           = vtIf.x;
        act.y           = vtIf.y;
        act.de          = vtIf.de;
        act.hsync       = vtIf.hsync;
        act.vsync       = vtIf.vsync;
        act.line_start  = vtIf.line_start;
        act.frame_start = vtIf.frame_start;
        testsRun++;
        if (expQueue.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboardEmpty t=%0t got %s, required a queued expectation", $time, fmtObs(act));
            return;
        end
        exp = expQueue.pop_front();
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL cycle t=%0t got %s required %s", $time, fmtObs(act), fmtObs(exp));
        end
    endtask

    // Monitor: one comparison per output cycle, plus one right after any asynchronous reset.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            checkOutput();
        end
    end

    initial begin
        int unsigned action;
        rst_n   = 1'b0;
        vtIf.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            stepModel();
        end
        #2;
        rst_n = 1'b1;

        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 2 * FRAME + 5);
        applyStimulus(1'b0, FRAME + 10);
        applyStimulus(1'b1, 60);
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, FRAME);
        applyReset(3, 1'b1);
        applyStimulus(1'b1, FRAME / 2);
        applyReset(2, 1'b0);
        applyStimulus(1'b0, 5);

        for (int iter = 0; iter < 30; iter++) begin
            action = $urandom_range(0, 7);
            if (action == 0) begin
                applyReset(int'($urandom_range(1, 4)), 1'(($urandom_range(0, 1))));
            end else begin
                applyStimulus(action > 2, int'($urandom_range(1, FRAME)));
            end
        end
        applyStimulus(1'b0, FRAME + 5);

        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
